// File: rtl/fma_seq_ctrl_pkg.sv
// Shared definitions for the serial FMA sequencer.
//   state_e    : state encodings, also driven onto the debug state port
//   cfg_t      : FMA configuration captured when a transaction is accepted
//   *_DEF      : default timing/size parameters for fma_seq_ctrl
package fma_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_COMP = 3'd3,
    ST_UNLD = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  typedef struct packed {
    logic [1:0] mode;
    logic [1:0] precision;
    logic [1:0] op;
  } cfg_t;

  localparam int FMA_LAT_DEF     = 4;
  localparam int LOAD_BITS_DEF   = 840;  // 12 rows x 70 bits
  localparam int UNLOAD_BITS_DEF = 300;  // 4 rows x 75 bits
  localparam int TO_MARGIN_DEF   = 16;
  localparam int CNT_W_DEF       = 11;

endpackage

// File: rtl/fma_seq_ctrl.sv
// Sequencer for the serial FMA top.
// Clears SIPO/PISO, shifts in operand rows, waits the FMA latency, shifts out
// result rows, and reports busy/done/timeout. Abort or timeout leaves through a
// one-cycle clear pulse back to IDLE.
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   start, abort                  host requests
//   mode_in, precision_in, op_in  FMA configuration, captured on accepted start
//   rFlag, tFlag                  SIPO all-received / PISO all-transmitted
//   en_sipo, rst_sipo             SIPO shift enable / active-low clear
//   en_piso, rst_piso             PISO shift enable / active-low clear
//   mode, precision, op           captured configuration to the FMA
//   busy, done, timeout, state    host status; state is debug visibility
// All outputs are registered and line up with the state register.
module fma_seq_ctrl
  import fma_seq_ctrl_pkg::*;
#(
  parameter int FMA_LAT     = FMA_LAT_DEF,
  parameter int LOAD_BITS   = LOAD_BITS_DEF,
  parameter int UNLOAD_BITS = UNLOAD_BITS_DEF,
  parameter int TO_MARGIN   = TO_MARGIN_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] mode_in,
  input  logic [1:0] precision_in,
  input  logic [1:0] op_in,
  input  logic       rFlag,
  input  logic       tFlag,
  output logic       en_sipo,
  output logic       rst_sipo,
  output logic       en_piso,
  output logic       rst_piso,
  output logic [1:0] mode,
  output logic [1:0] precision,
  output logic [1:0] op,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] LOAD_TERM = CNT_W'(LOAD_BITS + TO_MARGIN - 1);
  localparam logic [CNT_W-1:0] UNLD_TERM = CNT_W'(UNLOAD_BITS + TO_MARGIN - 1);
  localparam logic [CNT_W-1:0] COMP_TERM = CNT_W'(FMA_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Set when CLR is entered from abort/timeout: CLR then returns to IDLE.
  logic             exit_q, exit_d;
  logic             timeout_d;
  logic             accept;
  logic             en_sipo_d, en_piso_d, clr_d, busy_d, done_d;
  cfg_t             cfg_in;

  assign cfg_in = '{mode: mode_in, precision: precision_in, op: op_in};
  assign state  = state_q;

  // Counter holds at its terminal value rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] term);
    return (v == term) ? v : v + CNT_W'(1);
  endfunction

  // State register, cycle counter and exit flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      exit_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values together.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exit_q  <= exit_d;
    end
  end

  // Next-state logic. Abort outranks every flag; a flag outranks the
  // terminal count that lands in the same cycle.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    exit_d    = exit_q;
    timeout_d = timeout;
    accept    = 1'b0;
    if (state_q != ST_IDLE && abort) begin
      state_d = ST_CLR;
      cnt_d   = '0;
      exit_d  = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (start) begin
            accept    = 1'b1;
            timeout_d = 1'b0;
            exit_d    = 1'b0;
            state_d   = ST_CLR;
          end
        end
        ST_CLR: begin
          cnt_d   = '0;
          exit_d  = 1'b0;
          state_d = exit_q ? ST_IDLE : ST_LOAD;
        end
        ST_LOAD: begin
          if (rFlag) begin
            state_d = ST_COMP;
            cnt_d   = '0;
          end else if (cnt_q == LOAD_TERM) begin
            state_d   = ST_CLR;
            cnt_d     = '0;
            exit_d    = 1'b1;
            timeout_d = 1'b1;
          end else begin
            cnt_d = sat_inc(cnt_q, LOAD_TERM);
          end
        end
        ST_COMP: begin
          if (cnt_q == COMP_TERM) begin
            state_d = ST_UNLD;
            cnt_d   = '0;
          end else begin
            cnt_d = sat_inc(cnt_q, COMP_TERM);
          end
        end
        ST_UNLD: begin
          if (tFlag) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else if (cnt_q == UNLD_TERM) begin
            state_d   = ST_CLR;
            cnt_d     = '0;
            exit_d    = 1'b1;
            timeout_d = 1'b1;
          end else begin
            cnt_d = sat_inc(cnt_q, UNLD_TERM);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          exit_d  = 1'b0;
        end
      endcase
    end
  end

  // Output decode from the next state, so the registered outputs match the
  // state register in the same cycle.
  always_comb begin
    en_sipo_d = (state_d == ST_LOAD);
    en_piso_d = (state_d == ST_UNLD);
    clr_d     = (state_d == ST_CLR);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_sipo   <= 1'b0;
      en_piso   <= 1'b0;
      rst_sipo  <= 1'b1;
      rst_piso  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      mode      <= '0;
      precision <= '0;
      op        <= '0;
    end else begin
      en_sipo  <= en_sipo_d;
      en_piso  <= en_piso_d;
      rst_sipo <= !clr_d;
      rst_piso <= !clr_d;
      busy     <= busy_d;
      done     <= done_d;
      timeout  <= timeout_d;
      if (accept) begin
        mode      <= cfg_in.mode;
        precision <= cfg_in.precision;
        op        <= cfg_in.op;
      end
    end
  end

endmodule

// File: tb/tb_fma_seq_ctrl.sv
// Self-checking bench for fma_seq_ctrl. Each transaction is described as a
// timeline of phase lengths (CLR 1, LOAD r, COMP 4, UNLD t, DONE 1, or a
// cut-short path through CLR after abort/timeout). The expected outputs of
// every cycle follow from the phase of that cycle.
module tb_fma_seq_ctrl;

  localparam int FMA_LAT   = 4;
  localparam int LOAD_MAX  = 840 + 16;  // LOAD cycles before timeout
  localparam int UNLD_MAX  = 300 + 16;  // UNLD cycles before timeout
  localparam int P_IDLE = 0, P_CLR = 1, P_LOAD = 2, P_COMP = 3, P_UNLD = 4, P_DONE = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, abort = 1'b0, rFlag = 1'b0, tFlag = 1'b0;
  logic [1:0] mode_in = '0, precision_in = '0, op_in = '0;
  logic       en_sipo, rst_sipo, en_piso, rst_piso, busy, done, timeout;
  logic [1:0] mode, precision, op;
  logic [2:0] state;
  logic [15:0] obs;

  int checks = 0;
  int errors = 0;

  // Model state carried across transactions.
  bit       model_to  = 1'b0;
  bit [5:0] model_cfg = '0;
  bit       hold_cur  = 1'b0;

  // Per-cycle timeline of the current transaction.
  int q_st[$];
  bit q_r[$], q_t[$], q_ab[$], q_to[$];

  fma_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .mode_in(mode_in), .precision_in(precision_in), .op_in(op_in),
    .rFlag(rFlag), .tFlag(tFlag),
    .en_sipo(en_sipo), .rst_sipo(rst_sipo), .en_piso(en_piso), .rst_piso(rst_piso),
    .mode(mode), .precision(precision), .op(op),
    .busy(busy), .done(done), .timeout(timeout), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {state, en_sipo, rst_sipo, en_piso, rst_piso, busy, done, timeout,
                mode, precision, op};

  function automatic logic [15:0] exp_vec(int st, bit to, bit [5:0] cfg);
    return {3'(st), st == P_LOAD, st != P_CLR, st == P_UNLD, st != P_CLR,
            st != P_IDLE, st == P_DONE, to, cfg};
  endfunction

  task automatic check(input string tag, input int idx, input logic [15:0] got,
                       input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s idx=%0d observed=%h expected=%h", tag, idx, got, want);
    end
  endtask

  // Append len cycles of phase st. Flags that would end the phase stay low
  // inside it; elsewhere they toggle randomly and must be ignored.
  task automatic push_cycles(input int st, input int len);
    for (int i = 0; i < len; i++) begin
      q_st.push_back(st);
      q_r.push_back(st != P_LOAD && ((hold_cur && st == P_COMP) || $urandom_range(0, 3) == 0));
      q_t.push_back(st != P_UNLD && $urandom_range(0, 3) == 0);
      q_ab.push_back(1'b0);
      q_to.push_back(model_to);
    end
  endtask

  // r/t: LOAD/UNLD cycle number carrying rFlag/tFlag (0 = never raised).
  // ab_phase/ab_at: phase and cycle within it carrying abort (0 = none).
  task automatic run_txn(input string tag, input int r, input int t,
                         input int ab_phase, input int ab_at, input bit hold,
                         input bit [5:0] cfg);
    int  lens [6];
    bit  load_to, unld_to, bad;
    q_st.delete(); q_r.delete(); q_t.delete(); q_ab.delete(); q_to.delete();
    hold_cur  = hold;
    model_to  = 1'b0;
    model_cfg = cfg;
    load_to   = !(r >= 1 && r <= LOAD_MAX);
    unld_to   = !(t >= 1 && t <= UNLD_MAX);
    lens[P_IDLE] = 0;
    lens[P_CLR]  = 1;
    lens[P_LOAD] = load_to ? LOAD_MAX : r;
    lens[P_COMP] = FMA_LAT;
    lens[P_UNLD] = unld_to ? UNLD_MAX : t;
    lens[P_DONE] = 1;
    for (int p = P_CLR; p <= P_DONE; p++) begin
      if (ab_phase == p && ab_at >= 1 && ab_at <= lens[p]) begin
        push_cycles(p, ab_at);
        q_ab[q_ab.size()-1] = 1'b1;
        q_r[q_r.size()-1]   = 1'b1;
        q_t[q_t.size()-1]   = 1'b1;
        push_cycles(P_CLR, 1);
        break;
      end
      push_cycles(p, lens[p]);
      if (p == P_LOAD) begin
        if (load_to) begin model_to = 1'b1; push_cycles(P_CLR, 1); break; end
        q_r[q_r.size()-1] = 1'b1;
      end
      if (p == P_UNLD) begin
        if (unld_to) begin model_to = 1'b1; push_cycles(P_CLR, 1); break; end
        q_t[q_t.size()-1] = 1'b1;
      end
    end
    push_cycles(P_IDLE, 3);

    // Request the transaction from IDLE.
    {mode_in, precision_in, op_in} = cfg;
    start = 1'b1; rFlag = 1'b0; tFlag = 1'b0; abort = 1'b0;
    @(negedge clk);
    bad = 1'b0;
    for (int i = 0; i < q_st.size(); i++) begin
      if (!bad) begin
        check(tag, i, obs, exp_vec(q_st[i], q_to[i], model_cfg));
        bad = (obs !== exp_vec(q_st[i], q_to[i], model_cfg));
      end
      rFlag = q_r[i];
      tFlag = q_t[i];
      abort = q_ab[i];
      {mode_in, precision_in, op_in} = 6'($urandom);
      if (q_st[i] == P_IDLE) start = 1'b0;
      else                   start = hold ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0; rFlag = 1'b0; tFlag = 1'b0; abort = 1'b0;
    hold_cur = 1'b0;
  endtask

  initial begin
    // Power-on reset.
    #2 rst = 1'b0;
    #1 check("reset_por", 0, obs, exp_vec(P_IDLE, 1'b0, 6'd0));
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 0, obs, exp_vec(P_IDLE, 1'b0, 6'd0));

    run_txn("normal",     840, 300, 0, 0, 1'b0, {2'b01, 4'($urandom)});
    run_txn("load_to",      0, 300, 0, 0, 1'b0, 6'($urandom));
    run_txn("to_cleared", $urandom_range(LOAD_MAX, 1), $urandom_range(UNLD_MAX, 1),
            0, 0, 1'b0, 6'($urandom));
    run_txn("abort_unld", 840, 300, P_UNLD, 100, 1'b0, 6'($urandom));
    run_txn("hold_start", $urandom_range(LOAD_MAX, 1), $urandom_range(UNLD_MAX, 1),
            0, 0, 1'b1, 6'($urandom));
    run_txn("r_terminal", LOAD_MAX, $urandom_range(UNLD_MAX, 1), 0, 0, 1'b0, 6'($urandom));
    run_txn("t_terminal", $urandom_range(LOAD_MAX, 1), UNLD_MAX, 0, 0, 1'b0, 6'($urandom));
    run_txn("unld_to",    $urandom_range(LOAD_MAX, 1), 0, 0, 0, 1'b0, 6'($urandom));
    run_txn("abort_clr",  100, 100, P_CLR, 1, 1'b0, 6'($urandom));
    run_txn("abort_load_rflag", 200, 100, P_LOAD, 200, 1'b0, 6'($urandom));
    run_txn("abort_comp", 50, 50, P_COMP, $urandom_range(FMA_LAT, 1), 1'b0, 6'($urandom));
    run_txn("abort_done", 30, 20, P_DONE, 1, 1'b0, 6'($urandom));
    for (int k = 0; k < 3; k++)
      run_txn("random", $urandom_range(LOAD_MAX, 1), $urandom_range(UNLD_MAX, 1),
              0, 0, 1'b0, 6'($urandom));

    // Reset in the middle of LOAD: outputs drop to reset values at once.
    {mode_in, precision_in, op_in} = 6'b11_10_01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("pre_reset_clr", 0, obs, exp_vec(P_CLR, 1'b0, 6'b11_10_01));
    repeat (30) @(negedge clk);
    check("pre_reset_load", 30, obs, exp_vec(P_LOAD, 1'b0, 6'b11_10_01));
    #2 rst = 1'b0;
    #1 check("reset_mid_load", 0, obs, exp_vec(P_IDLE, 1'b0, 6'd0));
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_mid_reset", 0, obs, exp_vec(P_IDLE, 1'b0, 6'd0));

    run_txn("post_reset", $urandom_range(LOAD_MAX, 1), $urandom_range(UNLD_MAX, 1),
            0, 0, 1'b0, 6'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
